// File: rtl/reload_down_counter.sv
// Loadable down-counter/timer: counts to zero, pulses tc_o, then reloads or stops.
// All outputs registered, one cycle after the causing edge; no backpressure, en_i only gates counting.
module reload_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             mode_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (load_i) begin
      // A load overrides everything, including a terminal count due this cycle.
      state    <= RUN;
      count_q  <= load_val_i;
      reload_q <= load_val_i;
      mode_q   <= mode_i;
      tc_q     <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state)
        RUN: begin
          if (en_i) begin
            if (count_q != '0) begin
              count_q <= count_q - 1'b1;
            end else begin
              // Zero is handled here so the decrement never wraps.
              tc_q <= 1'b1;
              if (mode_q) begin
                count_q <= reload_q;
              end else begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          count_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_reload_down_counter.sv
// Directed bench for reload_down_counter: vector table plus hand-written multi-cycle sequences.
module tb_reload_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_i;
  logic [3:0] load_val_i;
  logic       mode_i;
  logic       en_i;
  logic [3:0] count_o;
  logic       tc_o;
  logic       busy_o;
  logic       done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reload_down_counter #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .mode_i     (mode_i),
    .en_i       (en_i),
    .count_o    (count_o),
    .tc_o       (tc_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct {
    logic       ld;
    logic [3:0] val;
    logic       md;
    logic       en;
    logic [3:0] c;
    logic       tc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [3:0] val, input logic md,
                              input logic en, input logic [3:0] c, input logic tc,
                              input logic busy, input logic done);
    vec_t v;
    v.ld = ld; v.val = val; v.md = md; v.en = en;
    v.c = c; v.tc = tc; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] val, input logic md, input logic en);
    load_i = ld; load_val_i = val; mode_i = md; en_i = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] c, input logic tc,
                           input logic busy, input logic done);
    chk({tag, "_count"}, 32'(count_o), 32'(c));
    chk({tag, "_tc"},    32'(tc_o),    32'(tc));
    chk({tag, "_busy"},  32'(busy_o),  32'(busy));
    chk({tag, "_done"},  32'(done_o),  32'(done));
  endtask

  // Loads `reload` in auto-reload mode and runs `cycles` enabled cycles against a reference model.
  task automatic run_periodic(input string tag, input int reload, input int cycles, input int exp_pulses);
    int   exp_c;
    int   pulses;
    logic exp_tc;
    exp_c  = reload;
    pulses = 0;
    drive(1'b1, 4'(reload), 1'b1, 1'b1);
    tick();
    check_out($sformatf("%s_load", tag), 4'(reload), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      tick();
      exp_tc = (exp_c == 0);
      exp_c  = (exp_c == 0) ? reload : exp_c - 1;
      check_out($sformatf("%s_c%0d", tag, i), 4'(exp_c), exp_tc, 1'b1, 1'b0);
      if (tc_o === 1'b1) pulses++;
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #2;
    check_out("por", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // One-shot load 3, then enable gating with load 4 auto-reload.
    vecs.push_back(mk(1, 4'd3, 0, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 1, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 1, 1, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd0, 1, 0, 1));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd0, 0, 0, 1));
    vecs.push_back(mk(1, 4'd4, 1, 0, 4'd4, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd4, 1, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd3, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd2, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd1, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 0, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 0, 1, 4'd4, 1, 1, 0));
    // One-shot with load value 0: a single enabled cycle, then DONE.
    vecs.push_back(mk(1, 4'd0, 0, 1, 4'd0, 0, 1, 0));
    vecs.push_back(mk(0, 4'd0, 1, 1, 4'd0, 1, 0, 1));
    vecs.push_back(mk(0, 4'd0, 1, 1, 4'd0, 0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].val, vecs[i].md, vecs[i].en);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].c, vecs[i].tc, vecs[i].busy, vecs[i].done);
    end

    // DONE is sticky with count held at 0.
    drive(1'b1, 4'd3, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd9, 1'b1, 1'b1);
      tick();
    end
    check_out("os_expire", 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("os_hold%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
    end

    run_periodic("ar2", 2, 12, 4);
    run_periodic("ar15", 15, 32, 2);
    run_periodic("ar0", 0, 5, 5);

    // Load priority over a terminal count in auto-reload.
    drive(1'b1, 4'd1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    check_out("lp_zero", 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'd6, 1'b0, 1'b1);
    tick();
    check_out("lp_load", 4'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 5; i >= 0; i--) begin
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      check_out($sformatf("lp_c%0d", i), 4'(i), 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_out("lp_done", 4'd0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-count, then IDLE until a load.
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    check_out("rst_pre", 4'd5, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_out("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("rst_idle%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
